// File: rtl/alu_pkg.sv
// Shared ALU types: opcode, status flags and lookahead group sizing.
// Used by the pipelined adder/subtractor and the future ALU top.
package alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  localparam int GROUP = 4;

  function automatic bit block_ok(input int blk);
    return (blk > 0) && (blk % GROUP == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group.
// Exports group generate/propagate for the next lookahead level.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       g,
  output logic       p,
  output logic       cout
);

  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:0] c;

  assign gi = a & b;
  assign pi = a ^ b;

  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0])
              | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1])
              | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);

  assign g = gi[3] | (pi[3] & gi[2])
           | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p = &pi;

  assign cout = g | (p & cin);
  assign sum  = pi ^ c;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one BLOCK slice per
// stage, elastic valid/ready flow control and registered flags.
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output flags_t           out_flags
);

  localparam int STAGES = WIDTH / BLOCK;
  localparam int NG     = BLOCK / GROUP;

  if (!block_ok(BLOCK) || (WIDTH % BLOCK) != 0) begin : g_bad
    $error("cla_addsub_pipe: WIDTH/BLOCK not supported");
  end

  // a/b skew forward unchanged; res collects finished slices.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             ovf;
    logic             z;
  } st_t;

  st_t              q [STAGES];
  st_t              src_in;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] up;
  logic [STAGES:0]   r;

  assign src_in = '{
    a:   in_a,
    b:   (in_op == OP_SUB) ? ~in_b : in_b,
    res: '0,
    c:   (in_op == OP_SUB),
    ovf: 1'b0,
    z:   1'b1
  };

  assign r[STAGES] = out_ready;
  assign in_ready  = r[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_st
    st_t              s;
    st_t              dn;
    st_t              sq;
    logic             vld;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    pp;
    logic [NG:0]      gc;
    logic [NG:0]      bg;
    logic [NG:0]      bp;
    logic [BLOCK-1:0] sum;
    logic             cst;
    logic             cmsb;

    if (i == 0) begin : g_head
      assign s     = src_in;
      assign up[i] = in_valid;
    end else begin : g_tail
      assign s     = q[i-1];
      assign up[i] = v[i-1];
    end

    assign gc[0] = s.c;
    assign bg[0] = 1'b0;
    assign bp[0] = 1'b1;

    for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group4 u_grp (
        .a    (s.a[i*BLOCK+k*GROUP +: GROUP]),
        .b    (s.b[i*BLOCK+k*GROUP +: GROUP]),
        .cin  (gc[k]),
        .sum  (sum[k*GROUP +: GROUP]),
        .g    (gg[k]),
        .p    (pp[k]),
        .cout (gc[k+1])
      );
      assign bg[k+1] = gg[k] | (pp[k] & bg[k]);
      assign bp[k+1] = pp[k] & bp[k];
    end

    // Stage carry-out from block-level generate/propagate.
    assign cst  = bg[NG] | (bp[NG] & s.c);
    assign cmsb = sum[BLOCK-1]
                ^ s.a[i*BLOCK+BLOCK-1]
                ^ s.b[i*BLOCK+BLOCK-1];

    always_comb begin
      dn = s;
      dn.res[i*BLOCK +: BLOCK] = sum;
      dn.c   = cst;
      dn.ovf = cmsb ^ cst;
      dn.z   = s.z & ~(|sum);
    end

    assign r[i] = !vld || r[i+1];
    assign v[i] = vld;
    assign q[i] = sq;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= 1'b0;
        sq  <= '0;
      end else if (r[i]) begin
        vld <= up[i];
        if (up[i]) sq <= dn;
      end
    end
  end

  assign out_valid  = v[STAGES-1];
  assign out_result = q[STAGES-1].res;
  assign out_flags  = '{
    carry:    q[STAGES-1].c,
    overflow: q[STAGES-1].ovf,
    zero:     q[STAGES-1].z,
    negative: q[STAGES-1].res[WIDTH-1]
  };

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: queued scoreboard on the 32-bit build,
// plus direct checks on 8/8 and 16/4 builds.
module tb_cla_addsub_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
  } exp_t;

  typedef struct packed {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  op_e         in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  flags_t      out_flags;

  logic        iv8, ir8, ov8, or8;
  op_e         op8;
  logic [7:0]  a8, b8, res8;
  flags_t      fl8;

  logic        iv16, ir16, ov16, or16;
  op_e         op16;
  logic [15:0] a16, b16, res16;
  flags_t      fl16;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  cla_addsub_pipe #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  cla_addsub_pipe #(.WIDTH(8), .BLOCK(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .in_op(op8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(or8),
    .out_result(res8), .out_flags(fl8)
  );

  cla_addsub_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .in_op(op16), .in_a(a16), .in_b(b16),
    .out_valid(ov16), .out_ready(or16),
    .out_result(res16), .out_flags(fl16)
  );

  function automatic exp_t model(input op_e op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] bb;
    logic        ovf;
    bb  = (op == OP_SUB) ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + 33'(op == OP_SUB);
    ovf = (a[31] == bb[31]) && (s[31] != a[31]);
    return {s[31:0], s[32], ovf, (s[31:0] == 32'd0), s[31]};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none",
                   out_result);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_result", 64'(out_result), 64'(mon_e.res));
          chk("sb_flags", 64'(out_flags), 64'(mon_e.fl));
        end
      end else if (sb.size() > 0) begin
        chk("stall_hold", 64'(out_result), 64'(sb[0].res));
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input op_e op, input logic [31:0] a,
                      input logic [31:0] b, input exp_t ex);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=0 required=1");
    end else begin
      sb.push_back(ex);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t burst [8];
  int   lat;
  int   wt;

  initial begin
    burst[0] = '{OP_ADD, 32'h0000_0001, 32'h0000_0002};
    burst[1] = '{OP_SUB, 32'h0000_0005, 32'h0000_0007};
    burst[2] = '{OP_ADD, 32'h8000_0000, 32'h8000_0000};
    burst[3] = '{OP_SUB, 32'h0000_0000, 32'h0000_0000};
    burst[4] = '{OP_ADD, 32'h1234_5678, 32'h9ABC_DEF0};
    burst[5] = '{OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    burst[6] = '{OP_ADD, 32'hDEAD_BEEF, 32'h2152_4111};
    burst[7] = '{OP_SUB, 32'h0000_0010, 32'h0000_0010};

    rst = 1'b1;
    in_valid = 1'b0; in_op = OP_ADD; in_a = '0; in_b = '0;
    out_ready = 1'b1;
    iv8 = 1'b0; op8 = OP_ADD; a8 = '0; b8 = '0; or8 = 1'b1;
    iv16 = 1'b0; op16 = OP_ADD; a16 = '0; b16 = '0; or16 = 1'b1;

    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_flags", 64'(out_flags), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // FFFFFFFF + 1: carry and zero, four-cycle latency
    @(posedge clk);
    #1;
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001,
         '{32'h0000_0000, 4'b1010});
    idle();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency32", 64'(lat), 64'd4);
    drain();

    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001,
         '{32'h8000_0000, 4'b0101});
    send(OP_SUB, 32'h8000_0000, 32'h0000_0001,
         '{32'h7FFF_FFFF, 4'b1100});
    idle();
    drain();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++)
      send(burst[i].op, burst[i].a, burst[i].b,
           model(burst[i].op, burst[i].a, burst[i].b));
    idle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(out_result), 64'd0);
    chk("midrst_flags", 64'(out_flags), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale", 64'(out_valid), 64'd0);

    // Backpressure burst
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i == 4) begin
            @(negedge clk);
            chk("in_ready_full", 64'(in_ready), 64'd0);
          end
          send(burst[i].op, burst[i].a, burst[i].b,
               model(burst[i].op, burst[i].a, burst[i].b));
        end
        idle();
      end
      begin
        wt = 0;
        do begin
          @(negedge clk);
          wt++;
        end while (!out_valid && wt < 30);
        chk("bp_first_valid", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // WIDTH=8, BLOCK=8: 0x0F - 0x10
    iv8 = 1'b1; op8 = OP_SUB; a8 = 8'h0F; b8 = 8'h10;
    @(negedge clk);
    chk("w8_in_ready", 64'(ir8), 64'd1);
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov8 && lat < 20);
    chk("w8_latency", 64'(lat), 64'd1);
    chk("w8_result", 64'(res8), 64'h0FF);
    chk("w8_flags", 64'(fl8), 64'(4'b0001));

    // WIDTH=16, BLOCK=4: 0x00FF + 0x0001
    @(posedge clk);
    #1;
    iv16 = 1'b1; op16 = OP_ADD; a16 = 16'h00FF; b16 = 16'h0001;
    @(negedge clk);
    chk("w16_in_ready", 64'(ir16), 64'd1);
    @(posedge clk);
    #1 iv16 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov16 && lat < 20);
    chk("w16_latency", 64'(lat), 64'd4);
    chk("w16_result", 64'(res16), 64'h0100);
    chk("w16_flags", 64'(fl16), 64'(4'b0000));

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
